// File: rtl/rv_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences ALU, memory port, IR and
// immediate extender for lw/sw/R/I/beq/jal, counts retirements, flags illegal opcodes.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC once memory is ready
// DECODE   | branch/jump target precomputed into ALUOut, dispatch on opcode
// MEMADR   | rs1 + imm -> ALUOut (load/store address)
// MEMREAD  | load data read at ALUOut, wait for memory
// MEMWB    | load data -> rd
// MEMWRITE | store data written at ALUOut, strobe held until memory ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | ALUOut -> rd (also PC+4 -> rd after JAL)
// BEQ      | rs1 - rs2, take branch target from ALUOut when zero
// JAL      | jump target from ALUOut -> PC, OldPC + 4 -> ALUOut
// ILLEGAL  | one-cycle illegal flag, no side effects

module rv_mc_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_adr_src,
    output logic        o_ir_write,
    output logic        o_mem_write,
    output logic        o_mem_req,
    output logic        o_reg_write,
    output logic [1:0]  o_result_src,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [2:0]  o_alu_control,
    output logic [1:0]  o_imm_src,
    output logic        o_illegal,
    output logic [31:0] o_retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] retired_cnt;
    logic        f3_alu_ok;
    logic        retire;
    logic [2:0]  alu_op;

    assign f3_alu_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) ||
                       (i_funct3 == 3'b110) || (i_funct3 == 3'b111);

    always_comb begin
        alu_op = ALU_ADD;
        case (i_funct3)
            3'b000:  alu_op = ((i_opcode == OP_R) && i_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:    if (i_mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_nxt = (i_funct3 == 3'b010) ? MEMADR : ILLEGAL;
                    OP_R:         state_nxt = f3_alu_ok ? EXECR : ILLEGAL;
                    OP_I:         state_nxt = f3_alu_ok ? EXECI : ILLEGAL;
                    OP_BEQ:       state_nxt = (i_funct3 == 3'b000) ? BEQ : ILLEGAL;
                    OP_JAL:       state_nxt = JAL;
                    default:      state_nxt = ILLEGAL;
                endcase
            end
            MEMADR:   state_nxt = (i_opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (i_mem_ready) state_nxt = MEMWB;
            MEMWB:    state_nxt = FETCH;
            MEMWRITE: if (i_mem_ready) state_nxt = FETCH;
            EXECR:    state_nxt = ALUWB;
            EXECI:    state_nxt = ALUWB;
            ALUWB:    state_nxt = FETCH;
            BEQ:      state_nxt = FETCH;
            JAL:      state_nxt = ALUWB;
            ILLEGAL:  state_nxt = FETCH;
            default:  state_nxt = FETCH;
        endcase
    end

    // JAL retires through ALUWB, so it is counted exactly once there.
    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                    ((state == MEMWRITE) && i_mem_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= FETCH;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (retire) retired_cnt <= retired_cnt + 32'd1;
        end
    end

    assign o_retired = retired_cnt;

    always_comb begin
        o_pc_write    = 1'b0;
        o_adr_src     = 1'b0;
        o_ir_write    = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_req     = 1'b0;
        o_reg_write   = 1'b0;
        o_result_src  = 2'b00;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_alu_control = ALU_ADD;
        o_imm_src     = 2'b00;
        o_illegal     = 1'b0;
        case (state)
            FETCH: begin
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
                o_imm_src   = (i_opcode == OP_JAL) ? 2'b11 : 2'b10;
            end
            MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                o_imm_src   = (i_opcode == OP_SW) ? 2'b01 : 2'b00;
            end
            MEMREAD: begin
                o_mem_req = 1'b1;
                o_adr_src = 1'b1;
            end
            MEMWB: begin
                o_result_src = 2'b01;
                o_reg_write  = 1'b1;
            end
            MEMWRITE: begin
                o_mem_req   = 1'b1;
                o_mem_write = 1'b1;
                o_adr_src   = 1'b1;
            end
            EXECR: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = alu_op;
            end
            EXECI: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b01;
                o_alu_control = alu_op;
            end
            ALUWB:   o_reg_write = 1'b1;
            BEQ: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = ALU_SUB;
                o_pc_write    = i_zero;
            end
            JAL: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                o_pc_write  = 1'b1;
            end
            ILLEGAL: o_illegal = 1'b1;
            default: ;
        endcase
        // State resets to FETCH, which would otherwise request memory during reset.
        if (!i_rst_n) begin
            o_pc_write  = 1'b0;
            o_ir_write  = 1'b0;
            o_mem_write = 1'b0;
            o_mem_req   = 1'b0;
            o_reg_write = 1'b0;
            o_illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed, table-driven bench for rv_mc_ctrl: per-cycle expected control vectors
// plus hand-written sequences for reset inside a store and counter wrap.

module tb_rv_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, adr_src, ir_write, mem_write, mem_req, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    rv_mc_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_zero(zero), .i_mem_ready(mem_ready),
        .o_pc_write(pc_write), .o_adr_src(adr_src), .o_ir_write(ir_write),
        .o_mem_write(mem_write), .o_mem_req(mem_req), .o_reg_write(reg_write),
        .o_result_src(result_src), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_alu_control(alu_control), .o_imm_src(imm_src), .o_illegal(illegal),
        .o_retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    // {pc_write, adr_src, ir_write, mem_write, mem_req, reg_write, illegal,
    //  result_src, alu_src_a, alu_src_b, alu_control, imm_src}
    function automatic logic [17:0] pk(logic pcw, logic adr, logic irw, logic mw, logic mr,
                                       logic rw, logic ill, logic [1:0] res, logic [1:0] sa,
                                       logic [1:0] sb, logic [2:0] alu, logic [1:0] imm);
        return {pcw, adr, irw, mw, mr, rw, ill, res, sa, sb, alu, imm};
    endfunction

    function automatic logic [17:0] s_fetch(logic rdy);
        return pk(rdy, 0, rdy, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
    endfunction
    function automatic logic [17:0] s_decode(logic [1:0] imm);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm);
    endfunction
    function automatic logic [17:0] s_memadr(logic [1:0] imm);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm);
    endfunction
    function automatic logic [17:0] s_memread();
        return pk(0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    endfunction
    function automatic logic [17:0] s_memwb();
        return pk(0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00);
    endfunction
    function automatic logic [17:0] s_memwrite();
        return pk(0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    endfunction
    function automatic logic [17:0] s_execr(logic [2:0] alu);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00);
    endfunction
    function automatic logic [17:0] s_execi(logic [2:0] alu);
        return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 2'b00);
    endfunction
    function automatic logic [17:0] s_aluwb();
        return pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    endfunction
    function automatic logic [17:0] s_beq(logic z);
        return pk(z, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00);
    endfunction
    function automatic logic [17:0] s_jal();
        return pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00);
    endfunction
    function automatic logic [17:0] s_illegal();
        return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [17:0] exp;
        logic [31:0] ret;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_v(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                         logic rdy, logic [17:0] exp, logic [31:0] ret);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
        v.exp = exp; v.ret = ret; v.name = name;
        vecs.push_back(v);
    endtask

    function automatic logic [17:0] act();
        return pk(pc_write, adr_src, ir_write, mem_write, mem_req, reg_write, illegal,
                  result_src, alu_src_a, alu_src_b, alu_control, imm_src);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check mid-cycle.
    task automatic step(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                        logic rdy, logic [17:0] exp, logic [31:0] ret);
        @(negedge clk);
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = rdy;
        #2;
        chk({name, ".ctl"}, {14'd0, act()}, {14'd0, exp});
        chk({name, ".ret"}, retired, ret);
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

        // add, sub, addi(f7=1 stays add), ori, slt, and
        add_v("add_f",  OP_R, 3'b000, 0, 0, 1, s_fetch(1),        0);
        add_v("add_d",  OP_R, 3'b000, 0, 0, 1, s_decode(2'b10),   0);
        add_v("add_x",  OP_R, 3'b000, 0, 0, 1, s_execr(3'b000),   0);
        add_v("add_w",  OP_R, 3'b000, 0, 0, 1, s_aluwb(),         0);
        add_v("sub_f",  OP_R, 3'b000, 1, 0, 1, s_fetch(1),        1);
        add_v("sub_d",  OP_R, 3'b000, 1, 0, 1, s_decode(2'b10),   1);
        add_v("sub_x",  OP_R, 3'b000, 1, 0, 1, s_execr(3'b001),   1);
        add_v("sub_w",  OP_R, 3'b000, 1, 0, 1, s_aluwb(),         1);
        add_v("addi_f", OP_I, 3'b000, 1, 0, 1, s_fetch(1),        2);
        add_v("addi_d", OP_I, 3'b000, 1, 0, 1, s_decode(2'b10),   2);
        add_v("addi_x", OP_I, 3'b000, 1, 0, 1, s_execi(3'b000),   2);
        add_v("addi_w", OP_I, 3'b000, 1, 0, 1, s_aluwb(),         2);
        add_v("ori_f",  OP_I, 3'b110, 0, 0, 1, s_fetch(1),        3);
        add_v("ori_d",  OP_I, 3'b110, 0, 0, 1, s_decode(2'b10),   3);
        add_v("ori_x",  OP_I, 3'b110, 0, 0, 1, s_execi(3'b011),   3);
        add_v("ori_w",  OP_I, 3'b110, 0, 0, 1, s_aluwb(),         3);
        add_v("slt_f",  OP_R, 3'b010, 0, 0, 1, s_fetch(1),        4);
        add_v("slt_d",  OP_R, 3'b010, 0, 0, 1, s_decode(2'b10),   4);
        add_v("slt_x",  OP_R, 3'b010, 0, 0, 1, s_execr(3'b101),   4);
        add_v("slt_w",  OP_R, 3'b010, 0, 0, 1, s_aluwb(),         4);
        add_v("and_f",  OP_R, 3'b111, 0, 0, 1, s_fetch(1),        5);
        add_v("and_d",  OP_R, 3'b111, 0, 0, 1, s_decode(2'b10),   5);
        add_v("and_x",  OP_R, 3'b111, 0, 0, 1, s_execr(3'b010),   5);
        add_v("and_w",  OP_R, 3'b111, 0, 0, 1, s_aluwb(),         5);
        // lw with one fetch wait and two MEMREAD waits
        add_v("lw_f0",  OP_LW, 3'b010, 0, 0, 0, s_fetch(0),       6);
        add_v("lw_f1",  OP_LW, 3'b010, 0, 0, 1, s_fetch(1),       6);
        add_v("lw_d",   OP_LW, 3'b010, 0, 0, 1, s_decode(2'b10),  6);
        add_v("lw_a",   OP_LW, 3'b010, 0, 0, 1, s_memadr(2'b00),  6);
        add_v("lw_r0",  OP_LW, 3'b010, 0, 0, 0, s_memread(),      6);
        add_v("lw_r1",  OP_LW, 3'b010, 0, 0, 0, s_memread(),      6);
        add_v("lw_r2",  OP_LW, 3'b010, 0, 0, 1, s_memread(),      6);
        add_v("lw_w",   OP_LW, 3'b010, 0, 0, 1, s_memwb(),        6);
        // sw with one write wait
        add_v("sw_f",   OP_SW, 3'b010, 0, 0, 1, s_fetch(1),       7);
        add_v("sw_d",   OP_SW, 3'b010, 0, 0, 1, s_decode(2'b10),  7);
        add_v("sw_a",   OP_SW, 3'b010, 0, 0, 1, s_memadr(2'b01),  7);
        add_v("sw_w0",  OP_SW, 3'b010, 0, 0, 0, s_memwrite(),     7);
        add_v("sw_w1",  OP_SW, 3'b010, 0, 0, 1, s_memwrite(),     7);
        // beq taken / not taken
        add_v("beq1_f", OP_BEQ, 3'b000, 0, 1, 1, s_fetch(1),      8);
        add_v("beq1_d", OP_BEQ, 3'b000, 0, 1, 1, s_decode(2'b10), 8);
        add_v("beq1_b", OP_BEQ, 3'b000, 0, 1, 1, s_beq(1),        8);
        add_v("beq0_f", OP_BEQ, 3'b000, 0, 0, 1, s_fetch(1),      9);
        add_v("beq0_d", OP_BEQ, 3'b000, 0, 0, 1, s_decode(2'b10), 9);
        add_v("beq0_b", OP_BEQ, 3'b000, 0, 0, 1, s_beq(0),        9);
        // jal
        add_v("jal_f",  OP_JAL, 3'b000, 0, 0, 1, s_fetch(1),      10);
        add_v("jal_d",  OP_JAL, 3'b000, 0, 0, 1, s_decode(2'b11), 10);
        add_v("jal_j",  OP_JAL, 3'b000, 0, 0, 1, s_jal(),         10);
        add_v("jal_w",  OP_JAL, 3'b000, 0, 0, 1, s_aluwb(),       10);
        // illegal encodings: none retire
        add_v("sys_f",  OP_SYS, 3'b000, 0, 0, 1, s_fetch(1),      11);
        add_v("sys_d",  OP_SYS, 3'b000, 0, 0, 1, s_decode(2'b10), 11);
        add_v("sys_i",  OP_SYS, 3'b000, 0, 0, 1, s_illegal(),     11);
        add_v("r1_f",   OP_R, 3'b001, 0, 0, 1, s_fetch(1),        11);
        add_v("r1_d",   OP_R, 3'b001, 0, 0, 1, s_decode(2'b10),   11);
        add_v("r1_i",   OP_R, 3'b001, 0, 0, 1, s_illegal(),       11);
        add_v("lwb_f",  OP_LW, 3'b000, 0, 0, 1, s_fetch(1),       11);
        add_v("lwb_d",  OP_LW, 3'b000, 0, 0, 1, s_decode(2'b10),  11);
        add_v("lwb_i",  OP_LW, 3'b000, 0, 0, 1, s_illegal(),      11);
        add_v("bne_f",  OP_BEQ, 3'b001, 0, 1, 1, s_fetch(1),      11);
        add_v("bne_d",  OP_BEQ, 3'b001, 0, 1, 1, s_decode(2'b10), 11);
        add_v("bne_i",  OP_BEQ, 3'b001, 0, 1, 1, s_illegal(),     11);
        add_v("end_f",  OP_R, 3'b000, 0, 0, 0, s_fetch(0),        11);

        // reset state: forced-low strobes and cleared counter
        #13;
        chk("rst.strobes", {26'd0, pc_write, ir_write, mem_write, mem_req, reg_write, illegal}, 32'd0);
        chk("rst.ret", retired, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z,
                 vecs[i].rdy, vecs[i].exp, vecs[i].ret);

        // reset while a store strobe is held
        step("rsw_f", OP_SW, 3'b010, 0, 0, 1, s_fetch(1),      11);
        step("rsw_d", OP_SW, 3'b010, 0, 0, 1, s_decode(2'b10), 11);
        step("rsw_a", OP_SW, 3'b010, 0, 0, 1, s_memadr(2'b01), 11);
        step("rsw_w", OP_SW, 3'b010, 0, 0, 0, s_memwrite(),    11);
        rst_n = 1'b0;
        #1;
        chk("rsw.mem_write", {31'd0, mem_write}, 32'd0);
        chk("rsw.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rsw.ret", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rsw.fetch", {14'd0, act()}, {14'd0, s_fetch(0)});

        // counter wrap: preload all ones while idling in FETCH
        force dut.retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt;
        step("wr_f", OP_R, 3'b000, 0, 0, 1, s_fetch(1),        32'hFFFF_FFFF);
        step("wr_d", OP_R, 3'b000, 0, 0, 1, s_decode(2'b10),   32'hFFFF_FFFF);
        step("wr_x", OP_R, 3'b000, 0, 0, 1, s_execr(3'b000),   32'hFFFF_FFFF);
        step("wr_w", OP_R, 3'b000, 0, 0, 1, s_aluwb(),         32'hFFFF_FFFF);
        step("wr_e", OP_R, 3'b000, 0, 0, 0, s_fetch(0),        32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
